// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with output/direction registers, synchronized inputs and edge interrupts
module gpio_ctrl #(
  parameter int GPIO_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  logic [GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d, ren_q, ren_d, fen_q, fen_d;
  logic [GPIO_W-1:0] stat_q, stat_d, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [GPIO_W-1:0] m, wd, clr, rise, fall;
  logic [31:0]       bmask;
  logic [9:0]        sel;
  logic              wr;
  assign sel   = addr[11:2];
  assign wr    = cs & we;
  assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign m     = bmask[GPIO_W-1:0];
  assign wd    = wdata[GPIO_W-1:0];
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign clr   = (wr && sel == 10'd5) ? (wd & m) : '0;
  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = |stat_q;
  // next-state: byte-masked register writes, input pipeline, sticky status where a new edge beats a clear
  always_comb begin
    dout_d  = (wr && sel == 10'd0) ? ((dout_q & ~m) | (wd & m)) : dout_q;
    dir_d   = (wr && sel == 10'd1) ? ((dir_q & ~m) | (wd & m)) : dir_q;
    ren_d   = (wr && sel == 10'd3) ? ((ren_q & ~m) | (wd & m)) : ren_q;
    fen_d   = (wr && sel == 10'd4) ? ((fen_q & ~m) | (wd & m)) : fen_q;
    stat_d  = (stat_q & ~clr) | (rise & ren_q) | (fall & fen_q);
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end
  // all state clears asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q  <= '0;
      dir_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      stat_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      stat_q  <= stat_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end
  // combinational read mux, zero when idle or writing
  always_comb begin
    rdata = '0;
    if (cs && !we)
      case (sel)
        10'd0:   rdata = 32'(dout_q);
        10'd1:   rdata = 32'(dir_q);
        10'd2:   rdata = 32'(sync2_q);
        10'd3:   rdata = 32'(ren_q);
        10'd4:   rdata = 32'(fen_q);
        10'd5:   rdata = 32'(stat_q);
        default: rdata = '0;
      endcase
  end
endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Memory-mapped GPIO peripheral occupying the 4 KB window 0xFFFF_2000–0xFFFF_2FFF, selected by the address decoder's `cs_gpio` output.
- Holds output-data, direction and interrupt-configuration registers.
- Double-synchronizes the input pins and detects rising/falling edges on them.
- Latches enabled edges into a write-1-to-clear status register that drives a level interrupt to the core.

## Interface
Parameters:
- `GPIO_W`, 32: number of GPIO pins, 1–32; register bits above `GPIO_W-1` read 0, writes to them are ignored.

Ports:
- `clk`, input, 1: single clock; every register is clocked on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all registers.
- `cs`, input, 1: chip select, driven by the decoder's `cs_gpio`.
- `we`, input, 1: write strobe; meaningful only while `cs`=1.
- `addr`, input, 12: byte offset within the window; `addr[11:2]` selects the register, `addr[1:0]` is ignored.
- `be`, input, 4: byte enables for writes; `be[k]` covers `wdata[8k+7:8k]`.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data, combinational.
- `gpio_in`, input, `GPIO_W`: asynchronous pin inputs.
- `gpio_out`, output, `GPIO_W`: pin output values; equals the DOUT register.
- `gpio_oe`, output, `GPIO_W`: per-pin output enables; equals the DIR register (1 = drive).
- `irq`, output, 1: level interrupt = OR of all IRQ_STAT bits.

## Operation
Register map (word offsets):
- 0x00 DOUT: read/write.
- 0x04 DIR: read/write.
- 0x08 DIN: read-only. Holds the synchronized pin values; writes are ignored.
- 0x0C RISE_EN: read/write. Enables latching of rising edges, per bit.
- 0x10 FALL_EN: read/write. Enables latching of falling edges, per bit.
- 0x14 IRQ_STAT: read / write-1-to-clear.
- Any other offset reads 0; writes to it have no effect.

Write rule:
- A write happens on the `clk` edge where `cs`=1 and `we`=1.
- Only the bytes whose `be` bit is set are updated.
- For IRQ_STAT, a 1 in an enabled byte clears that bit; a 0 leaves it unchanged.

Read rule:
- `rdata` is the addressed register whenever `cs`=1 and `we`=0; otherwise `rdata`=0.
- Reading any register has no side effects.

Input path:
- `sync1` <= `gpio_in`; `sync2` <= `sync1`; `prev` <= `sync2`.
- DIN = `sync2`.
- `rise` = `sync2 & ~prev`; `fall` = `~sync2 & prev`.
- Edges are detected on every pin, regardless of DIR.

Status update, per bit, each cycle:
- `stat_next = (stat & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)`.
- When an edge sets a bit in the same cycle that a W1C clears it, **set wins**.

Reset values:
- All registers and synchronizer flops are 0.
- Therefore `gpio_out`=0, `gpio_oe`=0 (all pins are inputs) and `irq`=0.
- `rdata`=0 unless a read is in progress.

Reset asserted mid-operation:
- All state clears immediately.
- Pending status bits are lost.
- A write whose edge coincides with `reset` is dropped.

## Timing
- Write latency: the register updates on the `clk` edge that samples the write. `gpio_out`/`gpio_oe` change right after that edge.
- Read latency: zero cycles. `rdata` is valid in the same cycle that `cs`, `we` and `addr` are presented, and reflects register state before any write on the coming edge.
- Pin-to-DIN latency: a pin change that is stable before edge E is visible in DIN after edge E+1 (2 edges).
- Pin-to-status latency: the matching IRQ_STAT bit sets on edge E+2; `irq` rises combinationally after E+2 (3 edges from the pin change).
- Clear-to-irq-low: `irq` falls right after the W1C edge, provided no other status bit is set and no new enabled edge arrives on that edge.
- Pulse filtering: a pin pulse shorter than one clock period may be missed; this is permitted.

## Test plan
- Reset defaults: assert `reset` mid-run with DOUT=0xFF → `gpio_out`, `gpio_oe`, `irq` and every readable register are 0 immediately; offset 0x20 reads 0.
- Byte-enable write: DOUT=0x11223344, then write 0xAABBCCDD with `be`=4'b0101 → DOUT reads 0x11BB33DD; a write to DIN leaves it unchanged.
- Input sync: drive `gpio_in`=0x5 before edge E → DIN reads 0 after E, reads 0x5 after E+1.
- Rising-edge irq: set RISE_EN=0x1, drive pin0 0→1 → IRQ_STAT=0x1 and `irq`=1 after 3 edges. W1C 0x1 → `irq`=0 on the next edge. Pin0 1→0 → no status set.
- Falling edge and masking: FALL_EN=0x2, RISE_EN=0. Toggle pin1 1→0 → IRQ_STAT=0x2. Toggle pin2 (not enabled) → no change.
- Set-wins collision: time a W1C of bit0 to land on the same edge as a new enabled rising edge of pin0 → IRQ_STAT bit0 stays 1 and `irq` stays 1.
